lectura_contadores: RTL and testbench

Readout sequencer for the per-FIFO transaction counter block. It drives that block's `state`, `req` and `idx` inputs, and holds the counters in ACTIVE while traffic flows. On a `start` request, while the transaction layer reports idle, it walks `idx` over all counters and captures each `cuenta`. It then publishes a packed snapshot plus the total, and returns the counters to ACTIVE. It sits between the transaction-layer main FSM and the counter block and replaces the hand-sequenced stimulus now used to read counters.

---
 rtl/contadores_pkg.sv | 24 ++
 rtl/lectura_contadores_lat_pipe.sv | 54 +++++
 rtl/lectura_contadores.sv | 153 +++++++++++++++
 tb/tb_lectura_contadores.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/contadores_pkg.sv
// ---------------------------------------------------------------------------
// contadores_pkg
// Shared definitions for the counter readout sequencer.
//   - one-hot mode encodings driven onto the counter block's `state` input
//   - sequencer FSM state enum
//   - default counter width
// ---------------------------------------------------------------------------
package contadores_pkg;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int CW_DEFAULT = 5;

    typedef enum logic [2:0] {
        RST,
        ACT,
        RD,
        DRAIN,
        FIN
    } fsm_t;

endpackage

// File: rtl/lectura_contadores_lat_pipe.sv
// ---------------------------------------------------------------------------
// lat_pipe
// Delay line that carries a read-valid bit and its counter index alongside
// the counter block's read latency, so that each returning `cuenta` can be
// tagged with the slot it belongs to.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               synchronous clear of every stage (readout cancelled)
//   in_valid, in_idx    issued read strobe and index
//   out_valid, out_idx  the same, DEPTH cycles later
// ---------------------------------------------------------------------------
module lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    logic [DEPTH-1:0] vld;
    logic [IW-1:0]    idx_q [DEPTH];

    // Stage 0 takes the issued read; each later stage copies its predecessor.
    // A flush empties the whole line so no stale capture survives an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld[0]   <= in_valid;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]   <= vld[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/lectura_contadores.sv
// ---------------------------------------------------------------------------
// lectura_contadores
// Readout sequencer for the per-FIFO transaction counter block. Keeps the
// counters in ACTIVE during traffic; on `start` while `idle`, switches them
// to read mode, walks `idx` over every counter, captures each `cuenta` into
// a shadow buffer, then publishes `snap` and `total` together with `done`.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        readout request (level, sampled each cycle)
//   idle         main FSM reports no traffic and all FIFOs empty
//   cuenta       counter value returned by the counter block
//   state        one-hot mode to the counter block (RESET/IDLE/ACTIVE)
//   req, idx     read strobe and counter index to the counter block
//   snap         captured values, counter i at [i*CW +: CW]
//   total        sum of the snapshot fields
//   busy         readout in progress
//   done, abort  one-cycle pulses: snapshot published / readout cancelled
// ---------------------------------------------------------------------------
module lectura_contadores
    import contadores_pkg::*;
#(
    parameter int N_CNT    = 4,
    parameter int CW       = CW_DEFAULT,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               idle,
    input  logic [CW-1:0]      cuenta,
    output logic [3:0]         state,
    output logic               req,
    output logic [2:0]         idx,
    output logic [N_CNT*CW-1:0] snap,
    output logic [CW+2:0]      total,
    output logic               busy,
    output logic               done,
    output logic               abort
);

    localparam logic [2:0] LAST_IDX = 3'(N_CNT - 1);

    fsm_t                fsm;
    logic [N_CNT*CW-1:0] shadow;
    logic [CW+2:0]       shadow_sum;
    logic                pipe_valid;
    logic [2:0]          pipe_idx;
    logic                flush;
    logic                last_capture;

    // Losing `idle` while reading cancels the readout and empties the pipe.
    assign flush        = ((fsm == RD) || (fsm == DRAIN)) && !idle;
    assign last_capture = pipe_valid && (pipe_idx == LAST_IDX);

    lat_pipe #(
        .DEPTH (READ_LAT),
        .IW    (3)
    ) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (req),
        .in_idx    (idx),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    // Each returning value lands in the slot named by the index that
    // travelled with it; `snap` is only touched when the readout commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (pipe_valid && !flush) begin
            shadow[int'(pipe_idx)*CW +: CW] <= cuenta;
        end
    end

    // Zero-extended sum of the shadow slots, registered into `total` at FIN.
    always_comb begin
        shadow_sum = '0;
        for (int i = 0; i < N_CNT; i++) begin
            shadow_sum = shadow_sum + {3'b000, shadow[i*CW +: CW]};
        end
    end

    // Sequencer: all outputs registered. The first `req` appears in the same
    // edge that accepts `start`; DRAIN waits for the last index to emerge
    // from the latency pipe, and FIN commits the shadow buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm   <= RST;
            state <= ST_RESET;
            req   <= 1'b0;
            idx   <= '0;
            snap  <= '0;
            total <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (fsm)
                RST: begin
                    fsm   <= ACT;
                    state <= ST_ACTIVE;
                end
                ACT: begin
                    if (start && idle) begin
                        fsm   <= RD;
                        state <= ST_IDLE;
                        busy  <= 1'b1;
                        req   <= 1'b1;
                        idx   <= '0;
                    end
                end
                RD, DRAIN: begin
                    if (!idle) begin
                        fsm   <= ACT;
                        state <= ST_ACTIVE;
                        req   <= 1'b0;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else if (fsm == RD) begin
                        if (idx == LAST_IDX) begin
                            fsm <= DRAIN;
                            req <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else if (last_capture) begin
                        fsm <= FIN;
                    end
                end
                FIN: begin
                    fsm   <= ACT;
                    state <= ST_ACTIVE;
                    snap  <= shadow;
                    total <= shadow_sum;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    fsm   <= ACT;
                    state <= ST_ACTIVE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lectura_contadores.sv
// ---------------------------------------------------------------------------
// tb_lectura_contadores
// Directed bench for the counter readout sequencer. Two instances share the
// clock and reset: one with default parameters, one with READ_LAT=3. Each
// has a small counter-block model returning cnt[idx] READ_LAT cycles after
// the registered `req`, and a junk value otherwise.
// ---------------------------------------------------------------------------
module tb_lectura_contadores;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, idle, start3, idle3;
    logic [4:0]  cuenta, cuenta3;
    logic [3:0]  state, state3;
    logic        req, req3;
    logic [2:0]  idx, idx3;
    logic [19:0] snap, snap3;
    logic [7:0]  total, total3;
    logic        busy, busy3, done, done3, abort, abort3;

    logic [4:0]  cnt [4];
    logic        lat1_v;
    logic [2:0]  lat1_idx;
    logic [2:0]  lat3_v;
    logic [2:0]  lat3_i0, lat3_i1, lat3_i2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lectura_contadores dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .idle   (idle),
        .cuenta (cuenta),
        .state  (state),
        .req    (req),
        .idx    (idx),
        .snap   (snap),
        .total  (total),
        .busy   (busy),
        .done   (done),
        .abort  (abort)
    );

    lectura_contadores #(
        .N_CNT    (4),
        .CW       (5),
        .READ_LAT (3)
    ) dut3 (
        .clk    (clk),
        .reset  (reset),
        .start  (start3),
        .idle   (idle3),
        .cuenta (cuenta3),
        .state  (state3),
        .req    (req3),
        .idx    (idx3),
        .snap   (snap3),
        .total  (total3),
        .busy   (busy3),
        .done   (done3),
        .abort  (abort3)
    );

    // Counter-block models: value valid READ_LAT cycles after registered req.
    always @(posedge clk) begin
        lat1_v   <= req;
        lat1_idx <= idx;
        lat3_v   <= {lat3_v[1:0], req3};
        lat3_i0  <= idx3;
        lat3_i1  <= lat3_i0;
        lat3_i2  <= lat3_i1;
    end

    assign cuenta  = lat1_v    ? cnt[lat1_idx[1:0]] : 5'd21;
    assign cuenta3 = lat3_v[2] ? cnt[lat3_i2[1:0]]  : 5'd21;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic i);
        start = s;
        idle  = i;
        @(negedge clk);
    endtask

    task automatic set_counters(input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [4:0] d);
        cnt[0] = a;
        cnt[1] = b;
        cnt[2] = c;
        cnt[3] = d;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_state"}, state, 4'b0001);
        check_output({tag, "_req"},   req,   1'b0);
        check_output({tag, "_idx"},   idx,   3'd0);
        check_output({tag, "_snap"},  snap,  20'd0);
        check_output({tag, "_total"}, total, 8'd0);
        check_output({tag, "_busy"},  busy,  1'b0);
        check_output({tag, "_done"},  done,  1'b0);
        check_output({tag, "_abort"}, abort, 1'b0);
    endtask

    // One full readout on the default instance: start sampled at E0, check
    // req/idx/busy/state/done after each of E0..E6 and the snapshot at E6.
    task automatic run_readout(input string tag, input logic [19:0] exp_snap, input logic [7:0] exp_total);
        apply_stimulus(1'b1, 1'b1);
        start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            check_output($sformatf("%s_req[%0d]", tag, k),   req,   (k < 4) ? 1'b1 : 1'b0);
            check_output($sformatf("%s_idx[%0d]", tag, k),   idx,   (k < 4) ? 3'(k) : 3'd3);
            check_output($sformatf("%s_busy[%0d]", tag, k),  busy,  (k < 6) ? 1'b1 : 1'b0);
            check_output($sformatf("%s_state[%0d]", tag, k), state, (k < 6) ? 4'b0100 : 4'b1000);
            check_output($sformatf("%s_done[%0d]", tag, k),  done,  (k == 6) ? 1'b1 : 1'b0);
        end
        check_output({tag, "_snap"},  snap,  exp_snap);
        check_output({tag, "_total"}, total, exp_total);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        idle   = 1'b1;
        start3 = 1'b0;
        idle3  = 1'b1;
        set_counters(5'd3, 5'd7, 5'd0, 5'd31);

        // Reset values, then one RST cycle before ACTIVE
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        check_output("rel_state0", state, 4'b0001);
        @(negedge clk);
        check_output("rel_state1", state, 4'b1000);
        check_output("rel_busy1",  busy,  1'b0);
        @(negedge clk);

        // Normal readout: counters 3,7,0,31 -> {31,0,7,3}, total 41
        run_readout("rd1", 20'hF80E3, 8'd41);

        // start without idle is ignored and not queued
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output($sformatf("noidle_req[%0d]", k),   req,   1'b0);
            check_output($sformatf("noidle_state[%0d]", k), state, 4'b1000);
            check_output($sformatf("noidle_busy[%0d]", k),  busy,  1'b0);
        end
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        check_output("noidle_queued_req", req, 1'b0);
        check_output("noidle_queued_busy", busy, 1'b0);

        // Abort: idle drops while idx=2
        set_counters(5'd1, 5'd2, 5'd3, 5'd4);
        apply_stimulus(1'b1, 1'b1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("ab_idx2", idx, 3'd2);
        check_output("ab_req2", req, 1'b1);
        idle = 1'b0;
        @(negedge clk);
        check_output("ab_abort", abort, 1'b1);
        check_output("ab_req",   req,   1'b0);
        check_output("ab_state", state, 4'b1000);
        check_output("ab_busy",  busy,  1'b0);
        check_output("ab_done",  done,  1'b0);
        check_output("ab_snap",  snap,  20'hF80E3);
        check_output("ab_total", total, 8'd41);
        idle = 1'b1;
        @(negedge clk);
        check_output("ab_abort_pulse", abort, 1'b0);
        check_output("ab_done_after",  done,  1'b0);
        check_output("ab_snap_after",  snap,  20'hF80E3);

        // Readout after abort completes normally: {4,3,2,1}, total 10
        run_readout("rd2", 20'h20C41, 8'd10);

        // Asynchronous reset during DRAIN
        apply_stimulus(1'b1, 1'b1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_output("drn_req", req, 1'b0);
        check_output("drn_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("drn_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("drn_rel_state", state, 4'b1000);
        check_output("drn_rel_snap",  snap,  20'd0);
        check_output("drn_rel_done",  done,  1'b0);
        check_output("drn_rel_abort", abort, 1'b0);

        // READ_LAT=3, start held: done every 9 cycles, {5,30,17,9} total 61
        set_counters(5'd9, 5'd17, 5'd30, 5'd5);
        start3 = 1'b1;
        idle3  = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4) begin
                check_output($sformatf("rl3_req[%0d]", k), req3, 1'b1);
                check_output($sformatf("rl3_idx[%0d]", k), idx3, 3'(k));
            end
            check_output($sformatf("rl3_done[%0d]", k), done3,
                         (k == 8 || k == 17 || k == 26) ? 1'b1 : 1'b0);
            if (k == 8 || k == 17 || k == 26) begin
                check_output($sformatf("rl3_snap[%0d]", k),  snap3,  20'h2FA29);
                check_output($sformatf("rl3_total[%0d]", k), total3, 8'd61);
            end
        end
        start3 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
